// File: rtl/regfile_seq_pkg.sv
// Shared constants, state encoding and decode helpers for the regfile_seq
// micro-operation sequencer.
package regfile_seq_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RD   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_WR1  = 3'd3,
    ST_WR2  = 3'd4,
    ST_CLR  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  function automatic logic is_write_state(input state_t st);
    return (st == ST_WR1) || (st == ST_WR2) || (st == ST_CLR);
  endfunction

  function automatic state_t first_state(input logic [2:0] op);
    state_t st;
    case (op)
      OP_NOP:  st = ST_DONE;
      OP_LDI:  st = ST_WR1;
      OP_MOV:  st = ST_RD1;
      OP_SWAP: st = ST_RD1;
      OP_SHL:  st = ST_RD1;
      OP_SHR:  st = ST_RD1;
      OP_CLR:  st = ST_CLR;
      OP_RD:   st = ST_RD1;
      default: st = ST_DONE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/regfile_seq_if.sv
// Command handshake plus register-file port bundle of the regfile_seq sequencer.
// slave = sequencer side, master = control unit / register-file environment.
interface regfile_seq_if;
  import regfile_seq_pkg::*;

  logic              start;
  logic [2:0]        op;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [DATA_W-1:0] imm;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              rf_wr;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_d_in;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_d_out;

  modport slave (
    input  start, op, src, dst, imm, rf_d_out,
    output busy, done, result, rf_wr, rf_wr_addr, rf_d_in, rf_rd_addr
  );

  modport master (
    output start, op, src, dst, imm, rf_d_out,
    input  busy, done, result, rf_wr, rf_wr_addr, rf_d_in, rf_rd_addr
  );

endinterface

// File: rtl/regfile_seq_shift.sv
// Combinational one-bit shifter for SHL/SHR. With REGFILE_SEQ_ROT_EN defined
// the vacated bit is filled by the bit shifted out (rotate), otherwise by zero.
module regfile_seq_shift
  import regfile_seq_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  logic              dir_right,
  output logic [DATA_W-1:0] dout
);

  // Shift or rotate by one position in the selected direction
  always_comb begin
    dout = {DATA_W{1'b0}};
`ifdef REGFILE_SEQ_ROT_EN
    if (dir_right) begin
      dout = {din[0], din[DATA_W-1:1]};
    end else begin
      dout = {din[DATA_W-2:0], din[DATA_W-1]};
    end
`else
    if (dir_right) begin
      dout = {1'b0, din[DATA_W-1:1]};
    end else begin
      dout = {din[DATA_W-2:0], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/regfile_seq.sv
// Micro-operation sequencer driving an external 8x8 register file; all outputs
// are registered, decoded from the next state. Shift mode set by REGFILE_SEQ_ROT_EN.
module regfile_seq
  import regfile_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  regfile_seq_if.slave  bus
);

  state_t            state_r, state_nx;
  logic [2:0]        op_r, op_nx;
  logic [ADDR_W-1:0] src_r, src_nx;
  logic [ADDR_W-1:0] dst_r, dst_nx;
  logic [DATA_W-1:0] imm_r, imm_nx;
  logic [DATA_W-1:0] t0_r, t0_nx;
  logic [DATA_W-1:0] t1_r, t1_nx;
  logic [2:0]        cnt_r, cnt_nx;

  logic              busy_r, busy_nx;
  logic              done_r, done_nx;
  logic [DATA_W-1:0] result_r, result_nx;
  logic              rf_wr_r, rf_wr_nx;
  logic [ADDR_W-1:0] rf_wr_addr_r, rf_wr_addr_nx;
  logic [DATA_W-1:0] rf_d_in_r, rf_d_in_nx;
  logic [ADDR_W-1:0] rf_rd_addr_r, rf_rd_addr_nx;

  logic [DATA_W-1:0] shift_s;
  logic [DATA_W-1:0] wr1_data_s;

  regfile_seq_shift u_shift (
    .din       (t0_nx),
    .dir_right (op_nx == OP_SHR),
    .dout      (shift_s)
  );

  // Next-state logic, command latching and temporary captures
  always_comb begin
    state_nx = state_r;
    op_nx    = op_r;
    src_nx   = src_r;
    dst_nx   = dst_r;
    imm_nx   = imm_r;
    t0_nx    = t0_r;
    t1_nx    = t1_r;
    cnt_nx   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          op_nx    = bus.op;
          src_nx   = bus.src;
          dst_nx   = bus.dst;
          imm_nx   = bus.imm;
          cnt_nx   = 3'd0;
          state_nx = first_state(bus.op);
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RD1: begin
        t0_nx = bus.rf_d_out;
        if (op_r == OP_RD) begin
          state_nx = ST_DONE;
        end else if (op_r == OP_SWAP) begin
          state_nx = ST_RD2;
        end else begin
          state_nx = ST_WR1;
        end
      end
      ST_RD2: begin
        t1_nx    = bus.rf_d_out;
        state_nx = ST_WR1;
      end
      ST_WR1: begin
        if (op_r == OP_SWAP) begin
          state_nx = ST_WR2;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_WR2: state_nx = ST_DONE;
      ST_CLR: begin
        if (cnt_r == 3'd7) begin
          cnt_nx   = 3'd0;
          state_nx = ST_DONE;
        end else begin
          cnt_nx   = cnt_r + 3'd1;
          state_nx = ST_CLR;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Data written in WR1, by opcode
  always_comb begin
    wr1_data_s = t0_nx;
    case (op_nx)
      OP_LDI:  wr1_data_s = imm_nx;
      OP_SHL:  wr1_data_s = shift_s;
      OP_SHR:  wr1_data_s = shift_s;
      default: wr1_data_s = t0_nx;
    endcase
  end

  // Output values for the state being entered, so outputs can be registered
  always_comb begin
    busy_nx       = (state_nx != ST_IDLE);
    done_nx       = (state_nx == ST_DONE);
    rf_wr_nx      = is_write_state(state_nx);
    rf_wr_addr_nx = {ADDR_W{1'b0}};
    rf_d_in_nx    = {DATA_W{1'b0}};
    rf_rd_addr_nx = src_nx;
    result_nx     = result_r;
    case (state_nx)
      ST_WR1: begin
        rf_wr_addr_nx = dst_nx;
        rf_d_in_nx    = wr1_data_s;
      end
      ST_WR2: begin
        rf_wr_addr_nx = src_nx;
        rf_d_in_nx    = t1_nx;
      end
      ST_CLR: begin
        rf_wr_addr_nx = cnt_nx;
        rf_d_in_nx    = {DATA_W{1'b0}};
      end
      ST_RD2: rf_rd_addr_nx = dst_nx;
      default: rf_rd_addr_nx = src_nx;
    endcase
    // SWAP reports the new dst, i.e. the old src value held in t0
    if (state_nx == ST_DONE) begin
      case (op_nx)
        OP_RD:   result_nx = t0_nx;
        OP_LDI:  result_nx = wr1_data_s;
        OP_MOV:  result_nx = wr1_data_s;
        OP_SHL:  result_nx = wr1_data_s;
        OP_SHR:  result_nx = wr1_data_s;
        OP_SWAP: result_nx = t0_nx;
        OP_CLR:  result_nx = {DATA_W{1'b0}};
        default: result_nx = result_r;
      endcase
    end else begin
      result_nx = result_r;
    end
  end

  // State, working registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      op_r         <= 3'd0;
      src_r        <= {ADDR_W{1'b0}};
      dst_r        <= {ADDR_W{1'b0}};
      imm_r        <= {DATA_W{1'b0}};
      t0_r         <= {DATA_W{1'b0}};
      t1_r         <= {DATA_W{1'b0}};
      cnt_r        <= 3'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      result_r     <= {DATA_W{1'b0}};
      rf_wr_r      <= 1'b0;
      rf_wr_addr_r <= {ADDR_W{1'b0}};
      rf_d_in_r    <= {DATA_W{1'b0}};
      rf_rd_addr_r <= {ADDR_W{1'b0}};
    end else begin
      state_r      <= state_nx;
      op_r         <= op_nx;
      src_r        <= src_nx;
      dst_r        <= dst_nx;
      imm_r        <= imm_nx;
      t0_r         <= t0_nx;
      t1_r         <= t1_nx;
      cnt_r        <= cnt_nx;
      busy_r       <= busy_nx;
      done_r       <= done_nx;
      result_r     <= result_nx;
      rf_wr_r      <= rf_wr_nx;
      rf_wr_addr_r <= rf_wr_addr_nx;
      rf_d_in_r    <= rf_d_in_nx;
      rf_rd_addr_r <= rf_rd_addr_nx;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.result     = result_r;
  assign bus.rf_wr      = rf_wr_r;
  assign bus.rf_wr_addr = rf_wr_addr_r;
  assign bus.rf_d_in    = rf_d_in_r;
  assign bus.rf_rd_addr = rf_rd_addr_r;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed self-checking bench for regfile_seq with a behavioural 8x8 register
// file beside the DUT and a write log for sequence checks.
module tb_regfile_seq;
  import regfile_seq_pkg::*;

`ifdef REGFILE_SEQ_ROT_EN
  localparam logic [7:0] EXP_SHL = 8'h03;
  localparam logic [7:0] EXP_SHR = 8'hC0;
`else
  localparam logic [7:0] EXP_SHL = 8'h02;
  localparam logic [7:0] EXP_SHR = 8'h40;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  regfile_seq_if bus();

  regfile_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [8];
  int         wr_cnt = 0;
  int         cyc = 0;
  logic [2:0] log_addr [256];
  logic [7:0] log_data [256];
  int         log_cyc  [256];

  assign bus.rf_d_out = mem[bus.rf_rd_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rf_wr === 1'b1) begin
      mem[bus.rf_wr_addr]     <= bus.rf_d_in;
      log_addr[wr_cnt[7:0]]   <= bus.rf_wr_addr;
      log_data[wr_cnt[7:0]]   <= bus.rf_d_in;
      log_cyc[wr_cnt[7:0]]    <= cyc;
      wr_cnt                  <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_busy"},   32'(bus.busy),       32'h0);
    check({pfx, "_done"},   32'(bus.done),       32'h0);
    check({pfx, "_rf_wr"},  32'(bus.rf_wr),      32'h0);
    check({pfx, "_result"}, 32'(bus.result),     32'h0);
    check({pfx, "_wraddr"}, 32'(bus.rf_wr_addr), 32'h0);
    check({pfx, "_rdaddr"}, 32'(bus.rf_rd_addr), 32'h0);
    check({pfx, "_din"},    32'(bus.rf_d_in),    32'h0);
  endtask

  // Issue one command in IDLE; lat = cycles from accepting edge to done, -1 on timeout
  task automatic do_cmd(input logic [2:0] o, input logic [2:0] s, input logic [2:0] d,
                        input logic [7:0] im, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src   = s;
    bus.dst   = d;
    bus.imm   = im;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] v);
    int lat;
    do_cmd(OP_RD, a, 3'd0, 8'h00, lat);
    v = bus.result;
  endtask

  initial begin
    int         lat;
    int         base;
    int         dones;
    int         wrs;
    int         bad;
    logic [7:0] v;

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.src   = 3'd0;
    bus.dst   = 3'd0;
    bus.imm   = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    reset = 1'b1;

    // LDI: one write, latency 2
    base = wr_cnt;
    do_cmd(OP_LDI, 3'd0, 3'd3, 8'hA5, lat);
    check("ldi_lat",    32'(lat), 32'd2);
    check("ldi_nwr",    32'(wr_cnt - base), 32'd1);
    check("ldi_addr",   32'(log_addr[base[7:0]]), 32'd3);
    check("ldi_data",   32'(log_data[base[7:0]]), 32'hA5);
    check("ldi_result", 32'(bus.result), 32'hA5);

    // Shifts of r1 = 0x81 into r2
    do_cmd(OP_LDI, 3'd0, 3'd1, 8'h81, lat);
    do_cmd(OP_SHL, 3'd1, 3'd2, 8'h00, lat);
    check("shl_lat",    32'(lat), 32'd3);
    check("shl_result", 32'(bus.result), 32'(EXP_SHL));
    read_reg(3'd2, v);
    check("shl_r2", 32'(v), 32'(EXP_SHL));
    do_cmd(OP_SHR, 3'd1, 3'd2, 8'h00, lat);
    check("shr_lat", 32'(lat), 32'd3);
    read_reg(3'd2, v);
    check("shr_r2", 32'(v), 32'(EXP_SHR));

    // SWAP r4 <-> r6, then SWAP with src == dst
    do_cmd(OP_LDI, 3'd0, 3'd4, 8'h11, lat);
    do_cmd(OP_LDI, 3'd0, 3'd6, 8'h22, lat);
    do_cmd(OP_SWAP, 3'd4, 3'd6, 8'h00, lat);
    check("swap_lat",    32'(lat), 32'd5);
    check("swap_result", 32'(bus.result), 32'h11);
    read_reg(3'd4, v);
    check("swap_r4", 32'(v), 32'h22);
    read_reg(3'd6, v);
    check("swap_r6", 32'(v), 32'h11);
    do_cmd(OP_SWAP, 3'd4, 3'd4, 8'h00, lat);
    check("swap_same_lat", 32'(lat), 32'd5);
    read_reg(3'd4, v);
    check("swap_same_r4", 32'(v), 32'h22);

    // MOV, RD latency, NOP leaves result alone
    do_cmd(OP_MOV, 3'd3, 3'd5, 8'h00, lat);
    check("mov_lat", 32'(lat), 32'd3);
    do_cmd(OP_RD, 3'd5, 3'd0, 8'h00, lat);
    check("rd_lat", 32'(lat), 32'd2);
    check("mov_r5", 32'(bus.result), 32'hA5);
    do_cmd(OP_NOP, 3'd0, 3'd0, 8'h00, lat);
    check("nop_lat",    32'(lat), 32'd1);
    check("nop_result", 32'(bus.result), 32'hA5);

    // CLR after filling with 0xFF
    for (int i = 0; i < 8; i++) do_cmd(OP_LDI, 3'd0, 3'(i), 8'hFF, lat);
    base = wr_cnt;
    do_cmd(OP_CLR, 3'd0, 3'd0, 8'h00, lat);
    check("clr_lat",    32'(lat), 32'd9);
    check("clr_nwr",    32'(wr_cnt - base), 32'd8);
    check("clr_result", 32'(bus.result), 32'h0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("clr_addr%0d", i), 32'(log_addr[8'(base + i)]), 32'(i));
      check($sformatf("clr_data%0d", i), 32'(log_data[8'(base + i)]), 32'h0);
      check($sformatf("clr_cyc%0d", i),  32'(log_cyc[8'(base + i)] - log_cyc[base[7:0]]), 32'(i));
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      check($sformatf("clr_rd%0d", i), 32'(v), 32'h0);
    end

    // start held high with MOV r0 -> r7: one acceptance per 4 cycles
    do_cmd(OP_LDI, 3'd0, 3'd0, 8'h3C, lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MOV;
    bus.src   = 3'd0;
    bus.dst   = 3'd7;
    dones = 0;
    wrs   = 0;
    bad   = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
      if (bus.rf_wr === 1'b1) wrs++;
      if (bus.rf_wr === 1'b1 && (bus.busy !== 1'b1 || bus.done === 1'b1)) bad++;
      if (i == 12) bus.start = 1'b0;
    end
    check("hold_dones", 32'(dones), 32'd3);
    check("hold_wrs",   32'(wrs),   32'd3);
    check("hold_bad",   32'(bad),   32'd0);
    read_reg(3'd7, v);
    check("hold_r7", 32'(v), 32'h3C);

    // Reset asserted during the third CLR write
    for (int i = 0; i < 8; i++) do_cmd(OP_LDI, 3'd0, 3'(i), 8'(8'h10 + i), lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_CLR;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_wr",   32'(bus.rf_wr), 32'h1);
    check("mid_addr", 32'(bus.rf_wr_addr), 32'd2);
    reset = 1'b0;
    #1;
    check_outputs_zero("mid");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      check($sformatf("mid_r%0d", i), 32'(v), (i < 2) ? 32'h0 : 32'(8'h10 + i));
    end
    do_cmd(OP_LDI, 3'd0, 3'd0, 8'h5A, lat);
    check("post_lat", 32'(lat), 32'd2);
    read_reg(3'd0, v);
    check("post_r0", 32'(v), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
